alu_share_arb: RTL and testbench



---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_req_buf.sv | 49 ++++
 rtl/alu_share_arb.sv | 125 ++++++++++++
 tb/tb_alu_share_arb.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU op encodings and the legal-op range used by the ALU arbiter.
// No logic; imported by alu_share_arb.
package alu_pkg;

  localparam int unsigned ALU_NOP  = 0;
  localparam int unsigned ALU_ADDU = 1;
  localparam int unsigned ALU_SUBU = 2;
  localparam int unsigned ALU_OR   = 3;
  localparam int unsigned ALU_SLL  = 4;
  localparam int unsigned ALU_SRL  = 5;
  localparam int unsigned ALU_SRA  = 6;

  localparam int unsigned ALU_OP_FIRST = ALU_ADDU;
  localparam int unsigned ALU_OP_LAST  = ALU_SRA;

  function automatic logic op_legal(input int unsigned op);
    return (op >= ALU_OP_FIRST) && (op <= ALU_OP_LAST);
  endfunction

endpackage

// File: rtl/alu_req_buf.sv
// One-entry request buffer: full flag plus op/a/b/s payload, ready = empty or issuing.
// Accepts on the same edge it issues, so a continuously granted port never bubbles.
module alu_req_buf #(
  parameter int W   = 32,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           valid,
  input  logic [OPW-1:0] op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [4:0]     s,
  input  logic           grant,
  output logic           ready,
  output logic           full,
  output logic [OPW-1:0] buf_op,
  output logic [W-1:0]   buf_a,
  output logic [W-1:0]   buf_b,
  output logic [4:0]     buf_s
);

  logic accept;

  assign ready  = !full || grant;
  assign accept = valid && ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full   <= 1'b0;
      buf_op <= '0;
      buf_a  <= '0;
      buf_b  <= '0;
      buf_s  <= '0;
    end else begin
      // A refill on the issue edge wins over the clear.
      if (accept) begin
        full   <= 1'b1;
        buf_op <= op;
        buf_a  <= a;
        buf_b  <= b;
        buf_s  <= s;
      end else if (grant) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Two-port arbiter sharing one combinational ALU; result registered and returned one edge after issue.
// Round-robin by default; ALU_ARB_FIXED_PRIO_EN selects fixed priority with port 0 always winning.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int W   = 32,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [OPW-1:0] req_op0,
  input  logic [OPW-1:0] req_op1,
  input  logic [W-1:0]   req_a0,
  input  logic [W-1:0]   req_a1,
  input  logic [W-1:0]   req_b0,
  input  logic [W-1:0]   req_b1,
  input  logic [4:0]     req_s0,
  input  logic [4:0]     req_s1,
  output logic [OPW-1:0] alu_ctrl,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [4:0]     alu_s,
  input  logic [W-1:0]   alu_d,
  output logic [1:0]     rsp_valid,
  output logic [W-1:0]   rsp_data,
  output logic           illegal_op
);

  logic [1:0]     full;
  logic [1:0]     grant;
  logic [OPW-1:0] buf_op [2];
  logic [W-1:0]   buf_a  [2];
  logic [W-1:0]   buf_b  [2];
  logic [4:0]     buf_s  [2];

  alu_req_buf #(.W(W), .OPW(OPW)) u_buf0 (
    .clk    (clk),
    .reset  (reset),
    .valid  (req_valid[0]),
    .op     (req_op0),
    .a      (req_a0),
    .b      (req_b0),
    .s      (req_s0),
    .grant  (grant[0]),
    .ready  (req_ready[0]),
    .full   (full[0]),
    .buf_op (buf_op[0]),
    .buf_a  (buf_a[0]),
    .buf_b  (buf_b[0]),
    .buf_s  (buf_s[0])
  );

  alu_req_buf #(.W(W), .OPW(OPW)) u_buf1 (
    .clk    (clk),
    .reset  (reset),
    .valid  (req_valid[1]),
    .op     (req_op1),
    .a      (req_a1),
    .b      (req_b1),
    .s      (req_s1),
    .grant  (grant[1]),
    .ready  (req_ready[1]),
    .full   (full[1]),
    .buf_op (buf_op[1]),
    .buf_a  (buf_a[1]),
    .buf_b  (buf_b[1]),
    .buf_s  (buf_s[1])
  );

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = 2'b00;
    if (full[0])      grant[0] = 1'b1;
    else if (full[1]) grant[1] = 1'b1;
  end
`else
  logic last;

  // last = 1 means port 1 was granted most recently, so port 0 wins a tie.
  always_comb begin
    grant = 2'b00;
    if (full[0] && (!full[1] || last)) grant[0] = 1'b1;
    else if (full[1])                  grant[1] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last <= 1'b1;
    else if (|grant) last <= grant[1];
  end
`endif

  // Idle drives NOP with zero operands so the shared ALU output settles to 0.
  always_comb begin
    alu_ctrl = OPW'(ALU_NOP);
    alu_a    = '0;
    alu_b    = '0;
    alu_s    = '0;
    if (grant[0]) begin
      alu_ctrl = buf_op[0];
      alu_a    = buf_a[0];
      alu_b    = buf_b[0];
      alu_s    = buf_s[0];
    end else if (grant[1]) begin
      alu_ctrl = buf_op[1];
      alu_a    = buf_a[1];
      alu_b    = buf_b[1];
      alu_s    = buf_s[1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid  <= 2'b00;
      rsp_data   <= '0;
      illegal_op <= 1'b0;
    end else begin
      rsp_valid <= grant;
      if (|grant) rsp_data <= alu_d;
      if (|grant && !op_legal(32'(alu_ctrl))) illegal_op <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb with a behavioural shared ALU and per-port result scoreboards.
// Honours ALU_ARB_FIXED_PRIO_EN when choosing the expected grant pattern.
module tb_alu_share_arb;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  s;
  } req_t;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_op0, req_op1;
  logic [31:0] req_a0, req_a1, req_b0, req_b1;
  logic [4:0]  req_s0, req_s1;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_a, alu_b, alu_d;
  logic [4:0]  alu_s;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        illegal_op;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int checks = 0;
  int passed = 0;

  alu_share_arb #(.W(32), .OPW(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op0    (req_op0),
    .req_op1    (req_op1),
    .req_a0     (req_a0),
    .req_a1     (req_a1),
    .req_b0     (req_b0),
    .req_b1     (req_b1),
    .req_s0     (req_s0),
    .req_s1     (req_s1),
    .alu_ctrl   (alu_ctrl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_s      (alu_s),
    .alu_d      (alu_d),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] s);
    case (op)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a | b;
      4'd4:    return b << s;
      4'd5:    return b >> s;
      4'd6:    return $unsigned($signed(b) >>> s);
      default: return 32'h0;
    endcase
  endfunction

  // The shared ALU sits outside the DUT.
  always_comb alu_d = alu_fn(alu_ctrl, alu_a, alu_b, alu_s);

  function automatic req_t mk(input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] s);
    req_t r;
    r.op = op; r.a = a; r.b = b; r.s = s;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (rsp_valid[0]) begin
        checks++;
        if (q0.size() == 0) $display("FAIL rsp0_unexpected: got %h, none expected", rsp_data);
        else begin
          logic [31:0] e0;
          e0 = q0.pop_front();
          if (rsp_data !== e0) $display("FAIL rsp0_data: got %h expected %h", rsp_data, e0);
          else passed++;
        end
      end
      if (rsp_valid[1]) begin
        checks++;
        if (q1.size() == 0) $display("FAIL rsp1_unexpected: got %h, none expected", rsp_data);
        else begin
          logic [31:0] e1;
          e1 = q1.pop_front();
          if (rsp_data !== e1) $display("FAIL rsp1_data: got %h expected %h", rsp_data, e1);
          else passed++;
        end
      end
    end
  end

  // Called at a negedge; drives one cycle of stimulus and returns at the next negedge.
  task automatic cycle(input logic v0, input req_t r0, input logic v1, input req_t r1);
    req_valid = {v1, v0};
    req_op0 = r0.op; req_a0 = r0.a; req_b0 = r0.b; req_s0 = r0.s;
    req_op1 = r1.op; req_a1 = r1.a; req_b1 = r1.b; req_s1 = r1.s;
    if (v0 && req_ready[0]) q0.push_back(alu_fn(r0.op, r0.a, r0.b, r0.s));
    if (v1 && req_ready[1]) q1.push_back(alu_fn(r1.op, r1.a, r1.b, r1.s));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, '0);
  endtask

  task automatic apply_reset();
    req_valid = 2'b00;
    reset = 1'b1;
    q0.delete();
    q1.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks += 8;
    if (req_ready !== 2'b11) $display("FAIL reset_ready: got %b expected 11", req_ready); else passed++;
    if (rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); else passed++;
    if (rsp_data !== 32'h0) $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); else passed++;
    if (illegal_op !== 1'b0) $display("FAIL reset_illegal: got %b expected 0", illegal_op); else passed++;
    if (alu_ctrl !== 4'h0) $display("FAIL reset_alu_ctrl: got %h expected 0", alu_ctrl); else passed++;
    if (alu_a !== 32'h0) $display("FAIL reset_alu_a: got %h expected 0", alu_a); else passed++;
    if (alu_b !== 32'h0) $display("FAIL reset_alu_b: got %h expected 0", alu_b); else passed++;
    if (alu_s !== 5'h0) $display("FAIL reset_alu_s: got %h expected 0", alu_s); else passed++;
    @(negedge clk);
    reset = 1'b0;
    idle();
    checks++;
    if (req_ready !== 2'b11) $display("FAIL post_reset_ready: got %b expected 11", req_ready); else passed++;
  endtask

  task automatic test_single();
    cycle(1'b1, mk(4'd1, 32'd5, 32'd7, 5'd0), 1'b0, '0);
    checks += 4;
    if (alu_ctrl !== 4'd1) $display("FAIL single_issue_ctrl: got %h expected 1", alu_ctrl); else passed++;
    if (alu_a !== 32'd5) $display("FAIL single_issue_a: got %h expected 5", alu_a); else passed++;
    if (alu_b !== 32'd7) $display("FAIL single_issue_b: got %h expected 7", alu_b); else passed++;
    if (rsp_valid !== 2'b00) $display("FAIL single_early_rsp: got %b expected 00", rsp_valid); else passed++;
    idle();
    checks += 3;
    if (rsp_valid !== 2'b01) $display("FAIL single_rsp_valid: got %b expected 01", rsp_valid); else passed++;
    if (rsp_data !== 32'd12) $display("FAIL single_rsp_data: got %h expected c", rsp_data); else passed++;
    if (alu_ctrl !== 4'h0 || alu_a !== 32'h0) $display("FAIL single_idle_alu: got %h/%h expected 0/0", alu_ctrl, alu_a); else passed++;
    idle();
    checks += 2;
    if (rsp_valid !== 2'b00) $display("FAIL single_rsp_pulse: got %b expected 00", rsp_valid); else passed++;
    if (rsp_data !== 32'd12) $display("FAIL single_rsp_hold: got %h expected c", rsp_data); else passed++;
  endtask

  task automatic test_both();
    apply_reset();
    cycle(1'b1, mk(4'd2, 32'd3, 32'd5, 5'd0), 1'b1, mk(4'd3, 32'hF0, 32'h0F, 5'd0));
    idle();
    checks += 2;
    if (rsp_valid !== 2'b01) $display("FAIL both_first_valid: got %b expected 01", rsp_valid); else passed++;
    if (rsp_data !== 32'hFFFFFFFE) $display("FAIL both_first_data: got %h expected fffffffe", rsp_data); else passed++;
    idle();
    checks += 2;
    if (rsp_valid !== 2'b10) $display("FAIL both_second_valid: got %b expected 10", rsp_valid); else passed++;
    if (rsp_data !== 32'h000000FF) $display("FAIL both_second_data: got %h expected 000000ff", rsp_data); else passed++;
    idle();
  endtask

  task automatic test_saturate();
    int n0, n1;
    logic [1:0] exp_v;
    n0 = 0;
    n1 = 0;
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, mk(4'd1, 32'(k), 32'd100, 5'd0), 1'b1, mk(4'd3, 32'(k) << 8, 32'd1, 5'd0));
      if (k >= 1 && k <= 8) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_v = 2'b01;
`else
        exp_v = (k % 2 == 1) ? 2'b01 : 2'b10;
`endif
        if (rsp_valid[0]) n0++;
        if (rsp_valid[1]) n1++;
        checks++;
        if (rsp_valid !== exp_v) $display("FAIL sat_pattern_%0d: got %b expected %b", k, rsp_valid, exp_v); else passed++;
      end
    end
    checks += 2;
`ifdef ALU_ARB_FIXED_PRIO_EN
    if (n0 != 8) $display("FAIL sat_count0: got %0d expected 8", n0); else passed++;
    if (n1 != 0) $display("FAIL sat_count1: got %0d expected 0", n1); else passed++;
`else
    if (n0 != 4) $display("FAIL sat_count0: got %0d expected 4", n0); else passed++;
    if (n1 != 4) $display("FAIL sat_count1: got %0d expected 4", n1); else passed++;
`endif
    for (int k = 0; k < 4; k++) idle();
  endtask

  task automatic test_stream();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (req_ready[1] !== 1'b1) $display("FAIL stream_ready_%0d: got %b expected 1", k, req_ready[1]); else passed++;
      cycle(1'b0, '0, 1'b1, mk(4'd6, 32'h1234, 32'h80000000, 5'd4));
      if (k >= 1) begin
        checks += 2;
        if (rsp_valid !== 2'b10) $display("FAIL stream_valid_%0d: got %b expected 10", k, rsp_valid); else passed++;
        if (rsp_data !== 32'hF8000000) $display("FAIL stream_data_%0d: got %h expected f8000000", k, rsp_data); else passed++;
      end
    end
    idle();
    idle();
  endtask

  task automatic test_illegal();
    apply_reset();
    cycle(1'b1, mk(4'd9, 32'd1, 32'd2, 5'd3), 1'b0, '0);
    checks++;
    if (illegal_op !== 1'b0) $display("FAIL illegal_early: got %b expected 0", illegal_op); else passed++;
    idle();
    checks += 3;
    if (rsp_valid !== 2'b01) $display("FAIL illegal_rsp_valid: got %b expected 01", rsp_valid); else passed++;
    if (rsp_data !== 32'h0) $display("FAIL illegal_rsp_data: got %h expected 0", rsp_data); else passed++;
    if (illegal_op !== 1'b1) $display("FAIL illegal_rise: got %b expected 1", illegal_op); else passed++;
    cycle(1'b1, mk(4'd1, 32'd1, 32'd1, 5'd0), 1'b0, '0);
    idle();
    idle();
    checks++;
    if (illegal_op !== 1'b1) $display("FAIL illegal_sticky: got %b expected 1", illegal_op); else passed++;
    apply_reset();
    checks++;
    if (illegal_op !== 1'b0) $display("FAIL illegal_clear: got %b expected 0", illegal_op); else passed++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    cycle(1'b1, mk(4'd1, 32'd1, 32'd1, 5'd0), 1'b1, mk(4'd3, 32'd2, 32'd4, 5'd0));
    checks++;
    if (req_ready !== 2'b01) $display("FAIL mid_ready_full: got %b expected 01", req_ready); else passed++;
    req_valid = 2'b00;
    reset = 1'b1;
    #1;
    q0.delete();
    q1.delete();
    checks += 2;
    if (req_ready !== 2'b11) $display("FAIL mid_reset_ready: got %b expected 11", req_ready); else passed++;
    if (rsp_valid !== 2'b00) $display("FAIL mid_reset_rsp: got %b expected 00", rsp_valid); else passed++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle();
    checks++;
    if (rsp_valid !== 2'b00) $display("FAIL mid_dropped_rsp: got %b expected 00", rsp_valid); else passed++;
    cycle(1'b1, mk(4'd1, 32'd10, 32'd20, 5'd0), 1'b1, mk(4'd2, 32'd50, 32'd8, 5'd0));
    idle();
    checks += 2;
    if (rsp_valid !== 2'b01) $display("FAIL mid_first_grant: got %b expected 01", rsp_valid); else passed++;
    if (rsp_data !== 32'd30) $display("FAIL mid_first_data: got %h expected 1e", rsp_data); else passed++;
    idle();
    checks += 2;
    if (rsp_valid !== 2'b10) $display("FAIL mid_second_grant: got %b expected 10", rsp_valid); else passed++;
    if (rsp_data !== 32'd42) $display("FAIL mid_second_data: got %h expected 2a", rsp_data); else passed++;
    idle();
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 2'b00;
    req_op0 = '0; req_a0 = '0; req_b0 = '0; req_s0 = '0;
    req_op1 = '0; req_a1 = '0; req_b1 = '0; req_s1 = '0;
    test_reset();
    test_single();
    test_both();
    test_saturate();
    test_stream();
    test_illegal();
    test_reset_mid();
    checks += 2;
    if (q0.size() != 0) $display("FAIL drain_q0: got %0d pending expected 0", q0.size()); else passed++;
    if (q1.size() != 0) $display("FAIL drain_q1: got %0d pending expected 0", q1.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
